// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Captures bytes from a UART receiver through a ready/clear handshake and
// buffers them in a DEPTH-entry byte FIFO that a CPU drains through RD_EN.
// A byte offered while the FIFO is full and not being popped is dropped,
// and the sticky OVERRUN flag records the loss.

module uart_rx_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          CLK50M,
   input  logic          n_RST,
   input  logic [7:0]    RX_DATA,
   input  logic          RX_RDY,
   output logic          RX_RDY_CLR,
   input  logic          RD_EN,
   output logic [7:0]    DOUT,
   output logic          EMPTY,
   output logic          FULL,
   output logic [AW:0]   COUNT,
   output logic          OVERRUN,
   input  logic          OVR_CLR
);

   // Capture handshake states: wait for ready, pulse the clear, then wait
   // for the receiver to drop its flag so a held flag is taken only once.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACK      = 2'd1,
      WAIT_LOW = 2'd2
   } cap_state_e;

   localparam logic [AW-1:0] PTR_ONE   = AW'(1);
   localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
   localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

   cap_state_e      state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q,  count_d;
   logic [7:0]      dout_q,   dout_d;
   logic            ovr_q,    ovr_d;
   logic [7:0]      mem_q [DEPTH];

   logic            capture;
   logic            pop;
   logic            wr_ok;
   logic            wr;
   logic            drop;
   logic            rdy_clr;

   // Flags come straight from the registered occupancy.
   assign EMPTY      = (count_q == '0);
   assign FULL       = (count_q == CNT_DEPTH);
   assign COUNT      = count_q;
   assign DOUT       = dout_q;
   assign OVERRUN    = ovr_q;
   assign RX_RDY_CLR = rdy_clr;

   // Capture, pop and write-permission decode for this cycle.
   always_comb begin
      capture = (state_q == IDLE) && RX_RDY;
      pop     = RD_EN && !EMPTY;
      // A pop frees the head slot in the same edge, so a full FIFO can
      // still accept a byte when it is being read.
      wr_ok   = !FULL || pop;
      wr      = capture && wr_ok;
      drop    = capture && !wr_ok;
   end

   // Next-state and output logic of the capture FSM.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      state_d = state_q;
      rdy_clr = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (RX_RDY) begin
               state_d = ACK;
            end
         end
         ACK: begin
            rdy_clr = 1'b1;
            state_d = WAIT_LOW;
         end
         WAIT_LOW: begin
            if (!RX_RDY) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Next values for pointers, occupancy, popped byte and overrun flag.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      dout_d   = dout_q;
      ovr_d    = ovr_q;

      if (wr) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
         dout_d   = mem_q[rd_ptr_q];
      end

      if (wr && !pop) begin
         count_d = count_q + CNT_ONE;
      end else if (pop && !wr) begin
         count_d = count_q - CNT_ONE;
      end

      // A drop in the same cycle as a clear request keeps the flag set.
      if (drop) begin
         ovr_d = 1'b1;
      end else if (OVR_CLR) begin
         ovr_d = 1'b0;
      end
   end

   // Control and status registers with synchronous active-low reset.
   always_ff @(posedge CLK50M) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of its neighbours.
      if (!n_RST) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= 8'h00;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
         ovr_q    <= ovr_d;
      end
   end

   // Byte storage written at the write pointer.
   always_ff @(posedge CLK50M) begin
      // NOTE: the storage array is deliberately not reset; the pointers and
      // count make stale contents unreachable, and leaving it unreset lets
      // it map onto plain registers or RAM.
      if (n_RST && wr) begin
         mem_q[wr_ptr_q] <= RX_DATA;
      end
   end

endmodule
